// File: rtl/key_event_filter_if.sv
// Key-filter port bundle: raw buttons in, debounced levels and one-hot key events out.
// fsm_state mirrors the auto-repeat FSM for observation only.
interface key_event_filter_if;
    logic [4:0] button_in;
    logic [4:0] button_out;
    logic [4:0] button_level;
    logic       repeat_active;
    logic [1:0] fsm_state;

    modport slave (
        input  button_in,
        output button_out,
        output button_level,
        output repeat_active,
        output fsm_state
    );

    modport master (
        output button_in,
        input  button_out,
        input  button_level,
        input  repeat_active,
        input  fsm_state
    );
endinterface

// File: rtl/key_event_filter.sv
// Synchronise, debounce and arbitrate five push-buttons into one-hot single-cycle
// key pulses, with press-and-hold auto-repeat for keys selected by REPEAT_MASK.
module key_event_filter #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         HOLD_CYCLES     = 50000000,
    parameter int         REPEAT_CYCLES   = 10000000,
    parameter logic [4:0] REPEAT_MASK     = 5'b10010
) (
    input  logic              clk_sys,
    input  logic              rst,
    key_event_filter_if.slave kif
);
    localparam int MAX_AB = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    logic [4:0]       meta_q, sync_q;
    logic [4:0]       level_q, level_d, level_prev_q;
    logic [CNT_W-1:0] db_cnt_q [5];
    logic [CNT_W-1:0] db_cnt_d [5];

    state_e           state_q, state_d;
    logic [4:0]       key_sel_q, key_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       out_q, out_d;
    logic             repeat_active_q;
    logic [4:0]       press;
    logic [4:0]       winner;

    // A bit's counter runs only while the synchronised input disagrees with the
    // accepted level, so any agreeing sample restarts the stability window.
    always_comb begin
        level_d = level_q;
        for (int b = 0; b < 5; b++) begin
            db_cnt_d[b] = '0;
            if (sync_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b] = ~level_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    assign press = level_q & ~level_prev_q;

    // Simultaneous presses: MID > UP > DOWN > LEFT > RIGHT, losers dropped.
    always_comb begin
        winner = '0;
        if (press[2])      winner = 5'b00100;
        else if (press[4]) winner = 5'b10000;
        else if (press[1]) winner = 5'b00010;
        else if (press[3]) winner = 5'b01000;
        else if (press[0]) winner = 5'b00001;
    end

    always_comb begin
        state_d   = state_q;
        key_sel_d = key_sel_q;
        cnt_d     = cnt_q;
        out_d     = '0;
        if (winner != '0) begin
            // A fresh press pre-empts any hold/repeat in progress.
            out_d = winner;
            cnt_d = '0;
            if ((winner & REPEAT_MASK) != '0) begin
                key_sel_d = winner;
                state_d   = ST_HOLD;
            end else begin
                key_sel_d = '0;
                state_d   = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_HOLD: begin
                    if ((level_q & key_sel_q) == '0) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == HOLD_LAST) begin
                        out_d   = key_sel_q;
                        cnt_d   = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if ((level_q & key_sel_q) == '0) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == REP_LAST) begin
                        out_d = key_sel_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            meta_q          <= '0;
            sync_q          <= '0;
            level_q         <= '0;
            level_prev_q    <= '0;
            for (int b = 0; b < 5; b++) db_cnt_q[b] <= '0;
            state_q         <= ST_IDLE;
            key_sel_q       <= '0;
            cnt_q           <= '0;
            out_q           <= '0;
            repeat_active_q <= 1'b0;
        end else begin
            meta_q          <= kif.button_in;
            sync_q          <= meta_q;
            level_q         <= level_d;
            level_prev_q    <= level_q;
            for (int b = 0; b < 5; b++) db_cnt_q[b] <= db_cnt_d[b];
            state_q         <= state_d;
            key_sel_q       <= key_sel_d;
            cnt_q           <= cnt_d;
            out_q           <= out_d;
            repeat_active_q <= (state_q == ST_REPEAT);
        end
    end

    assign kif.button_out    = out_q;
    assign kif.button_level  = level_q;
    assign kif.repeat_active = repeat_active_q;
    assign kif.fsm_state     = state_q;
endmodule

// File: tb/tb_key_event_filter.sv
// Randomised and directed stimulus for key_event_filter, checked every cycle against
// an event-time reference model of debounce, arbitration and auto-repeat.
module tb_key_event_filter;
    localparam int         D    = 4;
    localparam int         H    = 20;
    localparam int         R    = 8;
    localparam logic [4:0] MASK = 5'b10010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    key_event_filter_if kif ();

    key_event_filter #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk_sys(clk),
        .rst    (rst),
        .kif    (kif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, valid after the most recent rising edge.
    logic [4:0]  raw_h[$];
    logic [4:0]  m_lvl, m_lvl_d1, m_out, m_key;
    logic        m_ra, m_rep;
    int          m_due;
    int          cyc = 0;
    logic [10:0] exp_q[$];
    int          prio[5] = '{2, 4, 1, 3, 0};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h cycle=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0; m_lvl_d1 = '0; m_out = '0; m_key = '0;
        m_ra = 1'b0; m_rep = 1'b0; m_due = 0;
        raw_h.delete();
        for (int j = 0; j < D + 2; j++) raw_h.push_back(5'b0);
    endtask

    // A level flips once the last D synchronised samples all disagree with it;
    // events are scheduled as absolute cycle numbers from the press pulse.
    task automatic model_step(input logic [4:0] b, input logic r);
        logic [4:0] press, win, nl;
        logic       new_ra, all_diff;
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            raw_h.push_front(b);
            void'(raw_h.pop_back());
            press  = m_lvl & ~m_lvl_d1;
            win    = '0;
            for (int k = 0; k < 5; k++)
                if (win == '0 && press[prio[k]]) win[prio[k]] = 1'b1;
            new_ra = m_rep;
            m_out  = '0;
            if (win != '0) begin
                m_out = win;
                m_rep = 1'b0;
                if ((win & MASK) != '0) begin
                    m_key = win;
                    m_due = cyc + H;
                end else begin
                    m_key = '0;
                end
            end else if (m_key != '0) begin
                if ((m_lvl & m_key) == '0) begin
                    m_key = '0;
                    m_rep = 1'b0;
                end else if (cyc == m_due) begin
                    m_out = m_key;
                    m_due = cyc + R;
                    m_rep = 1'b1;
                end
            end
            for (int bi = 0; bi < 5; bi++) begin
                all_diff = 1'b1;
                for (int j = 2; j < D + 2; j++)
                    if (raw_h[j][bi] == m_lvl[bi]) all_diff = 1'b0;
                nl[bi] = all_diff ? ~m_lvl[bi] : m_lvl[bi];
            end
            m_lvl_d1 = m_lvl;
            m_lvl    = nl;
            m_ra     = new_ra;
        end
        exp_q.push_back({m_ra, m_lvl, m_out});
    endtask

    task automatic compare_outputs();
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("button_out", {27'd0, kif.button_out}, {27'd0, e[4:0]});
            check_val("button_level", {27'd0, kif.button_level}, {27'd0, e[9:5]});
            check_val("repeat_active", {31'd0, kif.repeat_active}, {31'd0, e[10]});
            check_val("onehot", {31'd0, ($countones(kif.button_out) <= 1)}, 32'd1);
        end
    endtask

    task automatic drive_cycle(input logic [4:0] b, input logic r);
        @(negedge clk);
        kif.button_in = b;
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            check_val("async_rst_out", {27'd0, kif.button_out}, 32'd0);
            check_val("async_rst_level", {27'd0, kif.button_level}, 32'd0);
            check_val("async_rst_ra", {31'd0, kif.repeat_active}, 32'd0);
        end else begin
            rst = r;
        end
        @(posedge clk);
        model_step(b, r);
        #1;
        compare_outputs();
    endtask

    task automatic hold(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) drive_cycle(b, 1'b0);
    endtask

    initial begin
        logic [4:0] v;
        int         len;
        kif.button_in = '0;
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(5'b0, 1'b1);
        hold(5'b0, 9);

        hold(5'b00100, 30);            // MID alone
        hold(5'b0, 10);

        drive_cycle(5'b10000, 1'b0);   // UP bounce, then stable
        drive_cycle(5'b00000, 1'b0);
        drive_cycle(5'b10000, 1'b0);
        drive_cycle(5'b10000, 1'b0);
        drive_cycle(5'b00000, 1'b0);
        hold(5'b10000, 80);
        hold(5'b0, 15);

        hold(5'b00101, 30);            // MID and RIGHT together
        hold(5'b0, 10);

        hold(5'b00010, 40);            // DOWN into repeat, then LEFT
        hold(5'b01010, 20);
        hold(5'b0, 15);

        hold(5'b10000, 40);            // reset while UP repeats
        drive_cycle(5'b10000, 1'b1);
        drive_cycle(5'b10000, 1'b1);
        hold(5'b10000, 50);
        hold(5'b0, 15);

        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 5))
                0, 1: begin v = 5'b1 << $urandom_range(0, 4); len = $urandom_range(5, 60); end
                2:    begin v = 5'($urandom_range(0, 31));    len = $urandom_range(1, 3);  end
                3:    begin v = 5'($urandom_range(0, 31));    len = $urandom_range(4, 40); end
                4:    begin v = '0;                            len = $urandom_range(1, 20); end
                default: begin v = ($urandom_range(0, 1) != 0) ? 5'b10000 : 5'b00010;
                               len = $urandom_range(30, 70); end
            endcase
            if ($urandom_range(0, 24) == 0) begin
                drive_cycle(v, 1'b1);
                drive_cycle(v, 1'b1);
            end
            hold(v, len);
        end
        hold(5'b0, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
